i2c_drive_arbiter: RTL



---
 rtl/i2c_drive_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/i2c_drive_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_drive_arbiter
//
// Routes one of NUM_SRC I2C line-driving sub-blocks (start/stop generator,
// receiver, transmitter, ...) onto the SDA/SCL pads. Whenever the selected
// source changes, the lines are frozen for GUARD_CYCLES cycles so that the
// handover cannot create a spurious START/STOP condition or an SCL glitch.
// Open-drain pull-low enables for the pad cells are produced alongside.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   drive_select  0 = release bus, k in 1..NUM_SRC = drive from source k-1,
//                 codes above NUM_SRC behave as 0
//   src_SDA       per-source SDA request (bit i = source i)
//   src_SCL       per-source SCL request (bit i = source i)
//   SDA_out       registered SDA level
//   SCL_out       registered SCL level
//   SDA_oe        pad pull-low enable, complement of SDA_out
//   SCL_oe        pad pull-low enable, complement of SCL_out
//   active_sel    effective select currently owning the lines (0 = released)
//   switching     high while a handover guard is in progress
// ---------------------------------------------------------------------------
module i2c_drive_arbiter #(
    parameter int NUM_SRC      = 3,
    parameter int SEL_W        = 2,
    parameter int GUARD_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SEL_W-1:0]   drive_select,
    input  logic [NUM_SRC-1:0] src_SDA,
    input  logic [NUM_SRC-1:0] src_SCL,
    output logic               SDA_out,
    output logic               SCL_out,
    output logic               SDA_oe,
    output logic               SCL_oe,
    output logic [SEL_W-1:0]   active_sel,
    output logic               switching
);

    localparam int CNT_W = (GUARD_CYCLES < 1) ? 1 : $clog2(GUARD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD =
        CNT_W'((GUARD_CYCLES > 0) ? (GUARD_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GUARD = 2'd2
    } state_t;

    state_t             state_q;
    logic [SEL_W-1:0]   active_q;
    logic [SEL_W-1:0]   target_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               sda_q;
    logic               scl_q;
    logic               switching_q;

    logic [SEL_W-1:0]   eff_sel;
    logic               act_sda;
    logic               act_scl;
    logic               tgt_sda;
    logic               tgt_scl;

    // Line value requested by the source behind a select code; code 0 is a
    // released (high) line.
    function automatic logic pick_line(input logic [SEL_W-1:0]   sel,
                                       input logic [NUM_SRC-1:0] vec);
        logic r;
        r = 1'b1;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel == SEL_W'(i + 1)) begin
                r = vec[i];
            end
        end
        return r;
    endfunction

    always_comb begin
        eff_sel = (drive_select <= SEL_W'(NUM_SRC)) ? drive_select : '0;
        act_sda = pick_line(active_q, src_SDA);
        act_scl = pick_line(active_q, src_SCL);
        tgt_sda = pick_line(target_q, src_SDA);
        tgt_scl = pick_line(target_q, src_SCL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            active_q    <= '0;
            target_q    <= '0;
            cnt_q       <= '0;
            sda_q       <= 1'b1;
            scl_q       <= 1'b1;
            switching_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DRIVE: begin
                    if (eff_sel != active_q) begin
                        // Lines are left untouched on the change edge; the new
                        // owner's values appear one cycle after active_sel moves.
                        if (GUARD_CYCLES == 0) begin
                            active_q <= eff_sel;
                            state_q  <= (eff_sel != '0) ? DRIVE : IDLE;
                        end else begin
                            state_q     <= GUARD;
                            switching_q <= 1'b1;
                            target_q    <= eff_sel;
                            cnt_q       <= CNT_LOAD;
                            // A one-cycle guard reaches count 0 on entry.
                            if (GUARD_CYCLES == 1) begin
                                active_q <= eff_sel;
                            end
                        end
                    end else begin
                        sda_q <= act_sda;
                        scl_q <= act_scl;
                    end
                end
                GUARD: begin
                    if (eff_sel != target_q) begin
                        // Select moved again: restart the whole guard period.
                        target_q <= eff_sel;
                        cnt_q    <= CNT_LOAD;
                        if (GUARD_CYCLES == 1) begin
                            active_q <= eff_sel;
                        end
                    end else if (cnt_q == '0) begin
                        state_q     <= (target_q != '0) ? DRIVE : IDLE;
                        switching_q <= 1'b0;
                        sda_q       <= tgt_sda;
                        scl_q       <= tgt_scl;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        // active_sel publishes the new owner in the last
                        // guard cycle, i.e. when the counter lands on 0.
                        if (cnt_q == CNT_W'(1)) begin
                            active_q <= target_q;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    switching_q <= 1'b0;
                    cnt_q       <= '0;
                end
            endcase
        end
    end

    assign SDA_out    = sda_q;
    assign SCL_out    = scl_q;
    assign SDA_oe     = ~sda_q;
    assign SCL_oe     = ~scl_q;
    assign active_sel = active_q;
    assign switching  = switching_q;

endmodule
